// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, requester IDs and boolean constants for mem_arb
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IF  = 2'd1,
    WAIT_LSU = 2'd2
  } arb_state_e;
  localparam logic ARB_ID_IF  = 1'b0;
  localparam logic ARB_ID_LSU = 1'b1;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way IF/LSU winner selector; ARB_RR_EN turns tie-breaking into round-robin
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic lsu_req_i,
`ifdef ARB_RR_EN
  input  logic last_i,
`endif
  output logic any_o,
  output logic win_o
);
  // Winner among active requesters; a tie goes to LSU, or away from the last winner when rotating
  always_comb begin
    any_o = if_req_i | lsu_req_i;
`ifdef ARB_RR_EN
    win_o = (if_req_i & lsu_req_i) ? (last_i == ARB_ID_LSU ? ARB_ID_IF : ARB_ID_LSU)
                                   : (lsu_req_i ? ARB_ID_LSU : ARB_ID_IF);
`else
    win_o = lsu_req_i ? ARB_ID_LSU : ARB_ID_IF;
`endif
  end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: IF/LSU arbiter onto one memory bus, one transaction outstanding; ARB_RR_EN enables round-robin ties
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                arb_busy
);
  arb_state_e state_q;
  logic       any;
  logic       win;
  logic       sel_lsu;
`ifdef ARB_RR_EN
  logic       last_grant_q;
  mem_arb_pick u_pick (
    .if_req_i (if_req),
    .lsu_req_i(lsu_req),
    .last_i   (last_grant_q),
    .any_o    (any),
    .win_o    (win)
  );
  // Remember the most recent winner so the next tie goes the other way
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant_q <= ARB_ID_LSU;
    else if (bus_req && bus_gnt) last_grant_q <= win;
`else
  mem_arb_pick u_pick (
    .if_req_i (if_req),
    .lsu_req_i(lsu_req),
    .any_o    (any),
    .win_o    (win)
  );
`endif
  // Claim the bus on a granted request, release it when the response arrives
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else case (state_q)
      IDLE:    if (bus_req && bus_gnt) state_q <= (win == ARB_ID_LSU) ? WAIT_LSU : WAIT_IF;
      default: if (bus_rvalid) state_q <= IDLE;
    endcase
  // Winner drives the bus combinationally while idle; payload is zeroed whenever no request
  always_comb begin
    sel_lsu    = (win == ARB_ID_LSU);
    bus_req    = rst_n & (state_q == IDLE) & any;
    bus_we     = bus_req & sel_lsu & lsu_we;
    bus_addr   = !bus_req ? '0 : (sel_lsu ? lsu_addr : if_addr);
    bus_wdata  = (bus_req & sel_lsu) ? lsu_wdata : '0;
    bus_be     = (bus_req & sel_lsu) ? lsu_be : '0;
    if_gnt     = bus_req & ~sel_lsu & bus_gnt;
    lsu_gnt    = bus_req & sel_lsu & bus_gnt;
    if_rvalid  = (state_q == WAIT_IF) & bus_rvalid;
    lsu_rvalid = (state_q == WAIT_LSU) & bus_rvalid;
    if_rdata   = bus_rdata;
    lsu_rdata  = bus_rdata;
    arb_busy   = (state_q != IDLE) | lsu_req | if_req;
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed plus random checks of mem_arb against a transaction-level model
module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int NONE = 0;
  localparam int IFR  = 1;
  localparam int LSU  = 2;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          lsu_req = 1'b0, lsu_we = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [BW-1:0] lsu_be = '0;
  logic          lsu_gnt, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [BW-1:0] bus_be;
  logic          bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          arb_busy;
  int n_assert = 0;
  int n_fail = 0;
  int own = NONE;
  int last = LSU;
  int win;
  bit e_breq, e_if_gnt, e_lsu_gnt;
  int grants[$];
  mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .arb_busy(arb_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Wait to mid-cycle and compare every output against the transaction model
  task automatic settle();
    @(negedge clk);
    if (!rst_n) begin own = NONE; last = LSU; end
    if (if_req && lsu_req) win = RR ? (last == LSU ? IFR : LSU) : LSU;
    else win = lsu_req ? LSU : IFR;
    e_breq    = rst_n && own == NONE && (if_req || lsu_req);
    e_if_gnt  = e_breq && win == IFR && bus_gnt;
    e_lsu_gnt = e_breq && win == LSU && bus_gnt;
    chk("bus_req", bus_req, e_breq);
    chk("bus_we", bus_we, e_breq && win == LSU && lsu_we);
    chk("bus_addr", bus_addr, !e_breq ? '0 : (win == LSU ? lsu_addr : if_addr));
    chk("bus_wdata", bus_wdata, (e_breq && win == LSU) ? lsu_wdata : '0);
    chk("bus_be", bus_be, (e_breq && win == LSU) ? lsu_be : '0);
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("lsu_gnt", lsu_gnt, e_lsu_gnt);
    chk("if_rvalid", if_rvalid, own == IFR && bus_rvalid);
    chk("lsu_rvalid", lsu_rvalid, own == LSU && bus_rvalid);
    chk("arb_busy", arb_busy, own != NONE || if_req || lsu_req);
    chk("if_rdata", if_rdata, bus_rdata);
    chk("lsu_rdata", lsu_rdata, bus_rdata);
  endtask
  // Advance one clock and update the model from the inputs of the cycle just ended
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin own = NONE; last = LSU; end
    else if (e_breq && bus_gnt) begin own = win; last = win; grants.push_back(win); end
    else if (own != NONE && bus_rvalid) own = NONE;
    #1;
  endtask
  initial begin
    int pulses;
    #1;
    lsu_req = 1'b1;
    settle();
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_lsu_gnt", lsu_gnt, 1'b0);
    tick();
    lsu_req = 1'b0;
    rst_n = 1'b1;
    settle(); tick();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100; bus_gnt = 1'b1;
    settle();
    chk("ld_gnt", lsu_gnt, 1'b1);
    chk("ld_addr", bus_addr, 32'h100);
    tick();
    lsu_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    settle();
    chk("ld_rvalid", lsu_rvalid, 1'b1);
    chk("ld_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("ld_if_rvalid", if_rvalid, 1'b0);
    tick();
    bus_rvalid = 1'b0;
    rst_n = 1'b0;
    settle(); tick();
    rst_n = 1'b1;
    grants.delete();
    if_req = 1'b1; if_addr = 32'h40; lsu_req = 1'b1; lsu_addr = 32'h80; bus_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_rvalid = k[0];
      settle(); tick();
    end
    chk("tie_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("tie_%0d", k), grants[k], RR ? (k[0] ? LSU : IFR) : LSU);
    if_req = 1'b0; bus_rvalid = 1'b0; bus_gnt = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200; lsu_wdata = 32'h12345678; lsu_be = 4'hF;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus_gnt = (i == 3);
      settle();
      chk("st_req", bus_req, 1'b1);
      chk("st_we", bus_we, 1'b1);
      chk("st_addr", bus_addr, 32'h200);
      chk("st_wdata", bus_wdata, 32'h12345678);
      chk("st_be", bus_be, 4'hF);
      chk("st_busy", arb_busy, 1'b1);
      pulses += int'(lsu_gnt);
      tick();
    end
    lsu_req = 1'b0; bus_gnt = 1'b0;
    settle();
    pulses += int'(lsu_gnt);
    chk("st_busy_wait", arb_busy, 1'b1);
    tick();
    bus_rvalid = 1'b1;
    settle();
    chk("st_rvalid", lsu_rvalid, 1'b1);
    chk("st_busy_ack", arb_busy, 1'b1);
    tick();
    bus_rvalid = 1'b0;
    settle();
    chk("st_gnt_pulses", pulses, 1);
    chk("st_busy_done", arb_busy, 1'b0);
    tick();
    if_req = 1'b1; if_addr = 32'h300; bus_gnt = 1'b1;
    settle(); tick();
    if_req = 1'b0; bus_gnt = 1'b0; rst_n = 1'b0;
    settle();
    chk("rst_mid_busy", arb_busy, 1'b0);
    tick();
    rst_n = 1'b1; bus_rvalid = 1'b1;
    settle();
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    tick();
    bus_rvalid = 1'b0; if_req = 1'b1;
    settle();
    chk("rst_idle_req", bus_req, 1'b1);
    tick();
    if_req = 1'b0; bus_rvalid = 1'b1;
    settle();
    chk("spur_if_rvalid", if_rvalid, 1'b0);
    chk("spur_lsu_rvalid", lsu_rvalid, 1'b0);
    chk("spur_bus_req", bus_req, 1'b0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (!if_req || e_if_gnt || $urandom_range(0, 15) == 0) begin
        if_req = $urandom_range(0, 2) != 0;
        if_addr = $urandom;
      end
      if (!lsu_req || e_lsu_gnt || $urandom_range(0, 15) == 0) begin
        lsu_req = $urandom_range(0, 2) != 0;
        lsu_we = 1'($urandom);
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
        lsu_be = 4'($urandom);
      end
      bus_gnt = 1'($urandom);
      bus_rvalid = 1'($urandom);
      bus_rdata = $urandom;
      rst_n = $urandom_range(0, 199) != 0;
      settle(); tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
